// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the shared ALU port and the ownership signals.
// The arbiter takes the slave view; the requesters/ALU side takes the master view.
interface alu_arbiter_if;
    logic [1:0]       i_lock;
    logic [1:0]       o_grant;
    logic [1:0]       o_preempt;

    logic [1:0][1:0]  i_req_input_op;
    logic [1:0]       i_req_data_valid;
    logic [1:0][31:0] i_req_data;
    logic [1:0][1:0]  i_req_output_op;
    logic [1:0]       i_req_result_empty;
    logic [1:0]       o_req_result_valid;
    logic [31:0]      o_req_result;
    logic [4:0]       o_req_result_flags;

    logic [1:0]       o_alu_input_op;
    logic             o_alu_data_valid;
    logic [31:0]      o_alu_data;
    logic [1:0]       o_alu_output_op;
    logic             o_alu_result_empty;
    logic             i_alu_result_valid;
    logic [31:0]      i_alu_result;
    logic [4:0]       i_alu_result_flags;

    modport slave (
        input  i_lock, i_req_input_op, i_req_data_valid, i_req_data, i_req_output_op,
               i_req_result_empty, i_alu_result_valid, i_alu_result, i_alu_result_flags,
        output o_grant, o_preempt, o_req_result_valid, o_req_result, o_req_result_flags,
               o_alu_input_op, o_alu_data_valid, o_alu_data, o_alu_output_op,
               o_alu_result_empty
    );

    modport master (
        output i_lock, i_req_input_op, i_req_data_valid, i_req_data, i_req_output_op,
               i_req_result_empty, i_alu_result_valid, i_alu_result, i_alu_result_flags,
        input  o_grant, o_preempt, o_req_result_valid, o_req_result, o_req_result_flags,
               o_alu_input_op, o_alu_data_valid, o_alu_data, o_alu_output_op,
               o_alu_result_empty
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin ownership arbiter sharing one ALU between two requesters, with result
// draining on release and hold-timeout preemption. Only state is registered.
module alu_arbiter #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    alu_arbiter_if.slave   bus
);
    localparam int unsigned     CntW      = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [CntW-1:0] CntMax    = CntW'(HOLD_MAX);
    localparam bit              PreemptEn = (HOLD_MAX != 0);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1, StDrain} state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      preempt_q, preempt_d;

    logic owner;
    logic owning;
    logic pick;
    logic hold_hit;

    assign owner    = (state_q == StOwn1);
    assign owning   = (state_q == StOwn0) || (state_q == StOwn1);
    assign hold_hit = PreemptEn && (cnt_q == CntMax) && (&bus.i_lock);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        preempt_d = '0;
        pick      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|bus.i_lock) begin
                    // On a tie the requester that did not own last time wins.
                    pick    = (&bus.i_lock) ? ~last_q : bus.i_lock[1];
                    state_d = pick ? StOwn1 : StOwn0;
                    last_d  = pick;
                    cnt_d   = '0;
                end
            end
            StOwn0, StOwn1: begin
                if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
                if (!bus.i_lock[owner] || hold_hit) begin
                    state_d = bus.i_alu_result_valid ? StDrain : StIdle;
                    // A lock drop wins over the timeout, so no pulse on release.
                    preempt_d[owner] = bus.i_lock[owner];
                end
            end
            StDrain: begin
                if (!bus.i_alu_result_valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            preempt_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end

    always_comb begin
        bus.o_grant            = {state_q == StOwn1, state_q == StOwn0};
        bus.o_preempt          = preempt_q;
        bus.o_req_result       = bus.i_alu_result;
        bus.o_req_result_flags = bus.i_alu_result_flags;
        bus.o_req_result_valid = '0;
        bus.o_alu_input_op     = '0;
        bus.o_alu_data_valid   = 1'b0;
        bus.o_alu_data         = '0;
        bus.o_alu_output_op    = '0;
        bus.o_alu_result_empty = 1'b0;
        if (owning) begin
            bus.o_alu_input_op            = bus.i_req_input_op[owner];
            bus.o_alu_data_valid          = bus.i_req_data_valid[owner];
            bus.o_alu_data                = bus.i_req_data[owner];
            bus.o_alu_output_op           = bus.i_req_output_op[owner];
            bus.o_alu_result_empty        = bus.i_req_result_empty[owner];
            bus.o_req_result_valid[owner] = bus.i_alu_result_valid;
        end else if (state_q == StDrain) begin
            // Pop and discard whatever result the departed owner left behind.
            bus.o_alu_result_empty = 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with HOLD_MAX=4, one with preemption off.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_arbiter_if ifc ();
    alu_arbiter_if ifc0 ();

    alu_arbiter #(.HOLD_MAX(4)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifc.slave)
    );

    alu_arbiter #(.HOLD_MAX(0)) u_dut_nopre (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifc0.slave)
    );

    typedef struct {
        string       tag;
        logic [1:0]  g;
        logic [1:0]  p;
        logic [1:0]  rv;
        logic [37:0] alu;
        logic [1:0]  g0;
        logic [36:0] res;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [37:0] AluZero  = '0;
    localparam logic [37:0] AluDrain = 38'd1;

    function automatic logic [37:0] alu_v(input logic [1:0] iop, input logic dv,
                                          input logic [31:0] d, input logic [1:0] oop,
                                          input logic re);
        return {iop, dv, d, oop, re};
    endfunction

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Push the expectation for this cycle, compare at the falling edge, then
    // advance to just after the next rising edge.
    task automatic chk(input string tag, input logic [1:0] g, input logic [1:0] p,
                       input logic [1:0] rv, input logic [37:0] alu, input logic [1:0] g0);
        exp_t e;
        e.tag = tag;
        e.g   = g;
        e.p   = p;
        e.rv  = rv;
        e.alu = alu;
        e.g0  = g0;
        e.res = {ifc.i_alu_result_flags, ifc.i_alu_result};
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        cmp({e.tag, ".grant"}, 64'(ifc.o_grant), 64'(e.g));
        cmp({e.tag, ".preempt"}, 64'(ifc.o_preempt), 64'(e.p));
        cmp({e.tag, ".rvalid"}, 64'(ifc.o_req_result_valid), 64'(e.rv));
        cmp({e.tag, ".alu"}, 64'({ifc.o_alu_input_op, ifc.o_alu_data_valid, ifc.o_alu_data,
                                  ifc.o_alu_output_op, ifc.o_alu_result_empty}), 64'(e.alu));
        cmp({e.tag, ".nopre"}, 64'({ifc0.o_grant, ifc0.o_preempt}), 64'({e.g0, 2'b00}));
        if (e.rv != 2'b00)
            cmp({e.tag, ".result"}, 64'({ifc.o_req_result_flags, ifc.o_req_result}),
                64'(e.res));
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifc.i_req_input_op     = '0;
        ifc.i_req_data_valid   = '0;
        ifc.i_req_data         = '0;
        ifc.i_req_output_op    = '0;
        ifc.i_req_result_empty = '0;
        ifc.i_alu_result_valid = 1'b0;
        ifc.i_alu_result       = '0;
        ifc.i_alu_result_flags = '0;
        ifc0.i_req_input_op     = '0;
        ifc0.i_req_data_valid   = '0;
        ifc0.i_req_data         = '0;
        ifc0.i_req_output_op    = '0;
        ifc0.i_req_result_empty = '0;
        ifc0.i_alu_result_valid = 1'b0;
        ifc0.i_alu_result       = '0;
        ifc0.i_alu_result_flags = '0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        ifc.i_lock  = '0;
        ifc0.i_lock = '0;
        clear_inputs();
        @(posedge clk);
        #1;
        chk("reset", 2'b00, 2'b00, 2'b00, AluZero, 2'b00);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // Single requester: forwarding and non-owner isolation.
        ifc.i_lock = 2'b01;
        chk("s1_idle", 2'b00, 2'b00, 2'b00, AluZero, 2'b00);
        ifc.i_req_data_valid   = 2'b11;
        ifc.i_req_data[0]      = 32'd5;
        ifc.i_req_data[1]      = 32'd99;
        ifc.i_req_input_op[1]  = 2'd3;
        ifc.i_req_result_empty = 2'b01;
        chk("s1_fwd", 2'b01, 2'b00, 2'b00, alu_v(2'd0, 1'b1, 32'd5, 2'd0, 1'b1), 2'b00);
        ifc.i_req_data_valid   = 2'b10;
        ifc.i_req_input_op[0]  = 2'd1;
        ifc.i_req_output_op[0] = 2'd2;
        ifc.i_alu_result_valid = 1'b1;
        ifc.i_alu_result       = 32'd7;
        ifc.i_alu_result_flags = 5'h11;
        chk("s1_res", 2'b01, 2'b00, 2'b01, alu_v(2'd1, 1'b0, 32'd5, 2'd2, 1'b1), 2'b00);
        clear_inputs();
        ifc.i_lock = 2'b00;
        chk("s1_rel", 2'b01, 2'b00, 2'b00, AluZero, 2'b00);
        chk("s1_idle2", 2'b00, 2'b00, 2'b00, AluZero, 2'b00);

        // Tie after reset goes to r0, then round-robin through one dead cycle.
        do_reset();
        ifc.i_lock = 2'b11;
        chk("rr_tie", 2'b00, 2'b00, 2'b00, AluZero, 2'b00);
        ifc.i_lock = 2'b10;
        chk("rr_g0", 2'b01, 2'b00, 2'b00, AluZero, 2'b00);
        chk("rr_dead", 2'b00, 2'b00, 2'b00, AluZero, 2'b00);
        ifc.i_lock = 2'b00;
        chk("rr_g1", 2'b10, 2'b00, 2'b00, AluZero, 2'b00);
        chk("rr_idle", 2'b00, 2'b00, 2'b00, AluZero, 2'b00);

        // Release with a pending result drains before the next grant.
        ifc.i_lock = 2'b01;
        chk("dr_idle0", 2'b00, 2'b00, 2'b00, AluZero, 2'b00);
        ifc.i_lock             = 2'b00;
        ifc.i_alu_result_valid = 1'b1;
        ifc.i_alu_result       = 32'h1234;
        ifc.i_alu_result_flags = 5'h03;
        chk("dr_rel", 2'b01, 2'b00, 2'b01, AluZero, 2'b00);
        ifc.i_lock             = 2'b01;
        ifc.i_req_data_valid   = 2'b01;
        ifc.i_req_data[0]      = 32'd3;
        chk("dr_1", 2'b00, 2'b00, 2'b00, AluDrain, 2'b00);
        ifc.i_alu_result_valid = 1'b0;
        chk("dr_2", 2'b00, 2'b00, 2'b00, AluDrain, 2'b00);
        chk("dr_idle", 2'b00, 2'b00, 2'b00, AluZero, 2'b00);
        ifc.i_lock = 2'b00;
        chk("dr_regrant", 2'b01, 2'b00, 2'b00, alu_v(2'd0, 1'b1, 32'd3, 2'd0, 1'b0), 2'b00);
        clear_inputs();
        chk("dr_end", 2'b00, 2'b00, 2'b00, AluZero, 2'b00);

        // Preemption after HOLD_MAX+1 owned cycles; disabled instance never yields.
        do_reset();
        ifc.i_lock  = 2'b11;
        ifc0.i_lock = 2'b11;
        chk("pre_c0", 2'b00, 2'b00, 2'b00, AluZero, 2'b00);
        for (int k = 0; k < 5; k++) chk("pre_own0", 2'b01, 2'b00, 2'b00, AluZero, 2'b01);
        chk("pre_pulse", 2'b00, 2'b01, 2'b00, AluZero, 2'b01);
        for (int k = 0; k < 4; k++) chk("pre_own1", 2'b10, 2'b00, 2'b00, AluZero, 2'b01);
        ifc.i_lock = 2'b01;
        chk("pre_drop", 2'b10, 2'b00, 2'b00, AluZero, 2'b01);
        chk("pre_nopulse", 2'b00, 2'b00, 2'b00, AluZero, 2'b01);
        rst_n = 1'b0;
        chk("pre_regrant", 2'b01, 2'b00, 2'b00, AluZero, 2'b01);
        rst_n      = 1'b1;
        ifc.i_lock = 2'b11;
        chk("pre_rst", 2'b00, 2'b00, 2'b00, AluZero, 2'b00);
        ifc.i_lock  = 2'b00;
        ifc0.i_lock = 2'b00;
        chk("pre_rst_tie", 2'b01, 2'b00, 2'b00, AluZero, 2'b01);
        chk("pre_end", 2'b00, 2'b00, 2'b00, AluZero, 2'b00);

        // Reset while r1 owns clears the grant and forwarding next cycle.
        ifc.i_lock = 2'b10;
        chk("rst1_idle", 2'b00, 2'b00, 2'b00, AluZero, 2'b00);
        ifc.i_req_data_valid  = 2'b10;
        ifc.i_req_data[1]     = 32'hAA;
        ifc.i_req_input_op[1] = 2'd2;
        rst_n = 1'b0;
        chk("rst1_own", 2'b10, 2'b00, 2'b00, alu_v(2'd2, 1'b1, 32'hAA, 2'd0, 1'b0), 2'b00);
        rst_n      = 1'b1;
        ifc.i_lock = 2'b11;
        chk("rst1_zero", 2'b00, 2'b00, 2'b00, AluZero, 2'b00);
        ifc.i_lock = 2'b00;
        clear_inputs();
        chk("rst1_tie", 2'b01, 2'b00, 2'b00, AluZero, 2'b00);
        chk("rst1_end", 2'b00, 2'b00, 2'b00, AluZero, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single `alu` instance between two requesters, for example the `cpu` core and a debug/DMA port. Each requester holds the ALU for a whole operand/result transaction, so the ALU's internal operand state is never interleaved. The block grants ownership round-robin and forwards the owner's ALU handshake. When ownership ends it drains any unconsumed result, and it preempts an owner that holds too long while the other requester waits.

## Interface
- `HOLD_MAX`, default 16: owned cycles before preemption becomes possible; 0 disables preemption.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  synchronous active-low reset.
- `i_lock`  in  2  per-requester ownership request/hold, bit r = requester r.
- `o_grant`  out  2  one-hot-or-zero ownership.
- `o_preempt`  out  2  one-cycle pulse: ownership was revoked by timeout.
- `i_req_input_op`  in  2x2  packed `{r1,r0}`.
- `i_req_data_valid`  in  2.
- `i_req_data`  in  2x32  packed.
- `i_req_output_op`  in  2x2  packed.
- `i_req_result_empty`  in  2.
- `o_req_result_valid`  out  2.
- `o_req_result`  out  32  shared, valid only where `o_req_result_valid` is set.
- `o_req_result_flags`  out  5  shared.
- `o_alu_input_op`  out  2  to `alu.i_input_op`.
- `o_alu_data_valid`  out  1.
- `o_alu_data`  out  32.
- `o_alu_output_op`  out  2.
- `o_alu_result_empty`  out  1.
- `i_alu_result_valid`  in  1  from `alu.o_result_valid`.
- `i_alu_result`  in  32.
- `i_alu_result_flags`  in  5.

## Operation
- States: IDLE, OWN0, OWN1, DRAIN.
- Registers: `last` (last owner), `cnt` (width `$clog2(HOLD_MAX+1)`, min 1).
- **IDLE**
  - No lock → stay.
  - One lock → OWN of that requester.
  - Both locks → OWN of `!last`.
  - On entering OWNr: `cnt` <= 0, `last` <= r.
- **OWNr**
  - `o_grant[r]`=1.
  - Requester r's `input_op`, `data_valid`, `data`, `output_op`, `result_empty` pass combinationally to the `o_alu_*` outputs.
  - `o_req_result_valid[r]` = `i_alu_result_valid`; the other bit is 0.
  - `o_req_result` and `o_req_result_flags` = ALU values, unmodified.
  - `cnt` increments each cycle, saturating at `HOLD_MAX`.
- **Release:** `i_lock[r]`=0 → DRAIN if `i_alu_result_valid`, else IDLE.
- **Preempt:** `HOLD_MAX`≠0, `cnt`==`HOLD_MAX`, `i_lock[r]`=1 and `i_lock[!r]`=1 → exit OWNr (DRAIN/IDLE rule as release) and `o_preempt[r]` <= 1 for one cycle.
- **Lock drop and preempt condition in the same cycle:** treated as release; no preempt pulse.
- **DRAIN**
  - `o_grant`=0.
  - `o_alu_result_empty`=1, `o_alu_output_op`=0, other `o_alu_*`=0.
  - Leaves to IDLE the cycle after `i_alu_result_valid` is sampled 0.
- **Not OWNr (IDLE/DRAIN):** all `o_alu_*` driven 0, except DRAIN's `result_empty`. Non-owner `i_req_*` is ignored.
- A preempted owner still holding lock re-competes in IDLE; round-robin hands the ALU to the other requester.
- **Reset values:** state IDLE, `last`=1 (requester 0 wins first tie), `cnt`=0, `o_grant`=0, `o_preempt`=0, all `o_alu_*`=0, `o_req_result_valid`=0.

## Timing
- Lock sampled at edge t → grant high in the cycle after t. Minimum lock-to-grant latency: 1 cycle.
- Lock low sampled at edge t → grant low after t. The ALU outputs stop following the requester in the same cycle the grant falls.
- Release to next grant:
  - ≥1 dead cycle through IDLE.
  - Through DRAIN: additional cycles while `i_alu_result_valid` is high.
- Preemption: with both locks held continuously from the grant, the owner keeps `o_grant` for exactly `HOLD_MAX`+1 cycles. `o_preempt` is high in the first cycle the grant is low.
- Reset mid-OWN or mid-DRAIN → IDLE at the next edge with `i_rst_n`=0. No drain is performed; the ALU's internal state is not cleared by this block.
- Forwarding paths are purely combinational. Only the grant/state is registered.

## Test plan
- **Single requester:** `i_lock`=01 at cycle 0.
  - → `o_grant`=01 from cycle 1.
  - r0 pushes data 5 with `input_op`=0 → `o_alu_data`=5, `o_alu_data_valid`=1 in the same cycle.
  - r1's `data_valid` pulses → no effect.
- **Tie and round-robin:** after reset `i_lock`=11 → grant 01. r0 drops lock → IDLE for 1 cycle → grant 10.
- **Drain:**
  - r0 releases while `i_alu_result_valid`=1.
  - → state DRAIN, `o_alu_result_empty`=1 until valid drops; no grant for that period.
  - Then IDLE, then grant.
- **Preempt** (`HOLD_MAX`=4, both locks held):
  - → r0 granted 5 cycles.
  - → `o_preempt`=01 for 1 cycle.
  - → r1 granted after IDLE.
  - `HOLD_MAX`=0 → r0 is never preempted.
- **Simultaneous drop at preempt cycle:** no `o_preempt` pulse.
- **Reset:** `i_rst_n`=0 while OWN1 → `o_grant`=00 and all `o_alu_*`=0 next cycle; after release of reset, first tie goes to r0.
